// File: rtl/mul_16b_seq.sv
// Sequential 16x16 shift-add multiplier built around one 32-bit ripple adder (fa_32b).
// Optional two's-complement operation is enabled by defining MUL_SIGNED_EN.

module fa_32b (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
endmodule

module mul_16b_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] product,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  dbg_state_o
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; valid holds its payload stable until that edge, and ready/valid
    // are decoded from registered state only.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
`ifdef MUL_SIGNED_EN
        NEG  = 2'd2,
`endif
        DONE = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [15:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] product_q, product_d;

    logic [31:0] fa_a, fa_b, fa_sum;
    logic        fa_cin;
    logic        unused_cout;

    logic [15:0] a_load, b_load;

`ifdef MUL_SIGNED_EN
    logic sign_q, sign_d;
    // -32768 negates to 0x8000, which is the correct magnitude read as unsigned.
    assign a_load = a[15] ? (~a + 16'd1) : a;
    assign b_load = b[15] ? (~b + 16'd1) : b;
`else
    assign a_load = a;
    assign b_load = b;
`endif

    fa_32b u_fa (
        .a    (fa_a),
        .b    (fa_b),
        .cin  (fa_cin),
        .sum  (fa_sum),
        .cout (unused_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
`ifdef MUL_SIGNED_EN
            sign_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
`ifdef MUL_SIGNED_EN
            sign_q    <= sign_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
`ifdef MUL_SIGNED_EN
        sign_d    = sign_q;
`endif
        fa_a      = acc_q;
        fa_b      = '0;
        fa_cin    = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = {16'd0, a_load};
                    mplier_d = b_load;
                    acc_d    = '0;
                    cnt_d    = '0;
`ifdef MUL_SIGNED_EN
                    sign_d   = a[15] ^ b[15];
`endif
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                fa_b     = mplier_q[0] ? mcand_q : '0;
                acc_d    = fa_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
`ifdef MUL_SIGNED_EN
                    state_d   = NEG;
`else
                    product_d = fa_sum;
                    state_d   = DONE;
`endif
                end
            end
`ifdef MUL_SIGNED_EN
            NEG: begin
                // Two's-complement negate as ~acc + 1 through the same adder.
                fa_a      = sign_q ? ~acc_q : acc_q;
                fa_cin    = sign_q;
                acc_d     = fa_sum;
                product_d = fa_sum;
                state_d   = DONE;
            end
`endif
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign product     = product_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mul_16b_seq.sv
// Bench for mul_16b_seq: directed vectors, expected queue filled on accept,
// monitor pops on every output handshake. Expectations follow MUL_SIGNED_EN.

module tb_mul_16b_seq;

`ifdef MUL_SIGNED_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 16;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] product;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  dbg_state;

    logic [31:0] exp_q[$];
    int          n_cmp;
    int          n_err;
    int          hs_cnt;

    mul_16b_seq dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .b           (b),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .product     (product),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            hs_cnt++;
            chk("ready_valid_exclusive", {31'd0, in_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_output: got 0x%08h expected no result", product);
            end else begin
                chk("product", product, exp_q.pop_front());
            end
        end
    end

    // driver: present operands, wait for acceptance, record the expected product
    task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic [31:0] exp);
        int guard;
        a = av;
        b = bv;
        in_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end
        @(posedge clk);
        exp_q.push_back(exp);
        #1;
        in_valid = 1'b0;
    endtask

    // counts edges after an accept until out_valid is seen
    task automatic wait_valid(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!out_valid && cycles < 100);
        if (!out_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL valid_timeout: got out_valid=0 expected 1");
        end
    endtask

    logic [15:0] bb_a   [5] = '{16'h00FF, 16'h1000, 16'hABCD, 16'h0000, 16'h7FFF};
    logic [15:0] bb_b   [5] = '{16'h0101, 16'h0010, 16'h0002, 16'h1234, 16'h7FFF};
`ifdef MUL_SIGNED_EN
    logic [31:0] bb_exp [5] = '{32'h0000FFFF, 32'h00010000, 32'hFFFF579A, 32'h00000000, 32'h3FFF0001};
`else
    logic [31:0] bb_exp [5] = '{32'h0000FFFF, 32'h00010000, 32'h0001579A, 32'h00000000, 32'h3FFF0001};
`endif

    initial begin
        int cyc;
        int hs0;
        int t_prev;
        int t_now;
        int guard;
        n_cmp = 0;
        n_err = 0;
        hs_cnt = 0;
        rst = 1'b1;
        a = '0;
        b = '0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_product", product, 32'd0);

        // basic: latency and return to idle
        out_ready = 1'b1;
        issue(16'd3, 16'd5, 32'h0000000F);
        wait_valid(cyc);
        chk("basic_latency", cyc, LAT);
        @(posedge clk);
        #1;
        chk("basic_in_ready_back", {31'd0, in_ready}, 32'd1);
        chk("basic_out_valid_low", {31'd0, out_valid}, 32'd0);
        chk("basic_product_held", product, 32'h0000000F);

`ifdef MUL_SIGNED_EN
        issue(16'hFFFF, 16'hFFFF, 32'h00000001);
        wait_valid(cyc);
        issue(16'hFFFD, 16'h0005, 32'hFFFFFFF1);
        wait_valid(cyc);
`else
        issue(16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        wait_valid(cyc);
        issue(16'hFFFD, 16'h0005, 32'h0004FFF1);
        wait_valid(cyc);
`endif
        issue(16'h8000, 16'h8000, 32'h40000000);
        wait_valid(cyc);
        @(posedge clk);
        #1;

        // backpressure plus ignored in_valid while busy
        out_ready = 1'b0;
        issue(16'h1234, 16'h0100, 32'h00123400);
        a = 16'd7;
        b = 16'd7;
        in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("busy_in_ready_low", {31'd0, in_ready}, 32'd0);
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        hs0 = hs_cnt;
        for (int i = 0; i < 10; i++) begin
            chk("bp_product_stable", product, 32'h00123400);
            chk("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_one_handshake", hs_cnt - hs0, 1);
        chk("bp_ignored_operands", exp_q.size(), 0);

        // reset in the middle of BUSY
        issue(16'd9, 16'd9, 32'd81);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_product", product, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(16'd2, 16'd2, 32'd4);
        wait_valid(cyc);
        @(posedge clk);
        #1;

        // back-to-back with in_valid held high
        out_ready = 1'b1;
        in_valid = 1'b1;
        t_prev = 0;
        for (int i = 0; i < 5; i++) begin
            a = bb_a[i];
            b = bb_b[i];
            guard = 0;
            @(negedge clk);
            while (!in_ready && guard < 100) begin
                guard++;
                @(negedge clk);
            end
            @(posedge clk);
            t_now = int'($time / 10);
            exp_q.push_back(bb_exp[i]);
            if (i > 0) chk("b2b_accept_spacing", t_now - t_prev, LAT + 2);
            t_prev = t_now;
            #1;
        end
        in_valid = 1'b0;

        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        repeat (3) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
